// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 32x32 shift-add multiplier, signed or unsigned, built around a single CLA adder.
// Signed operands are converted to magnitudes, multiplied unsigned, then the 64-bit product is negated if needed.

module cla_adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] S,
    output logic        overflow
);
    logic [31:0] g, p;
    logic [32:0] c;

    function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp, input logic ci);
        cla4[0] = gg[0] | (pp[0] & ci);
        cla4[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        cla4[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
        cla4[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
                | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    endfunction

    assign g = A & B;
    assign p = A ^ B;

    // 4-bit lookahead groups; group carries chain between groups
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int j = 0; j < 8; j++)
            c[4*j+1 +: 4] = cla4(g[4*j +: 4], p[4*j +: 4], c[4*j]);
    end

    assign S        = p ^ c[31:0];
    assign overflow = c[32] ^ c[31];
endmodule

module shift_add_multiplier (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  count_q, count_d;
    logic        sign_q, sign_d, signed_q, signed_d, lz_q, lz_d;
    logic [31:0] add_a, add_b, add_s, mplier_abs;
    logic        add_cin, add_co, add_ovf_unused;

    cla_adder32 u_add (
        .A        (add_a),
        .B        (add_b),
        .cin      (add_cin),
        .S        (add_s),
        .overflow (add_ovf_unused)
    );

    // The adder only reports signed overflow, so rebuild the unsigned carry-out
    assign add_co = (add_a[31] & add_b[31]) | ((add_a[31] | add_b[31]) & ~add_s[31]);

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ABS_A:  begin add_a = ~mcand_q;  add_cin = 1'b1; end
            ABS_B:  begin add_a = ~mplier_q; add_cin = 1'b1; end
            MUL:    begin add_a = hi_q; add_b = lo_q[0] ? mcand_q : '0; end
            NEG_LO: begin add_a = ~lo_q; add_cin = 1'b1; end
            NEG_HI: begin add_a = ~hi_q; add_cin = lz_q; end
            default: ;
        endcase
    end

    assign mplier_abs = (signed_q & mplier_q[31]) ? add_s : mplier_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        count_d  = count_q;
        sign_d   = sign_q;
        signed_d = signed_q;
        lz_d     = lz_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d  = A;
                mplier_d = B;
                signed_d = is_signed;
                sign_d   = is_signed & (A[31] ^ B[31]);
                hi_d     = '0;
                lo_d     = is_signed ? '0 : B;
                count_d  = '0;
                state_d  = is_signed ? ABS_A : MUL;
            end
            ABS_A: begin
                mcand_d = (signed_q & mcand_q[31]) ? add_s : mcand_q;
                state_d = ABS_B;
            end
            ABS_B: begin
                mplier_d = mplier_abs;
                lo_d     = mplier_abs;
                count_d  = '0;
                state_d  = MUL;
            end
            MUL: begin
                hi_d    = {add_co, add_s[31:1]};
                lo_d    = {add_s[0], lo_q[31:1]};
                // bitwise incrementer, saturating at 31 on the final pass
                count_d = (&count_q) ? count_q
                        : count_q ^ {&count_q[3:0], &count_q[2:0], &count_q[1:0], count_q[0], 1'b1};
                if (&count_q)
                    state_d = sign_q ? NEG_LO : DONE;
            end
            NEG_LO: begin
                lo_d    = add_s;
                lz_d    = add_co;
                state_d = NEG_HI;
            end
            NEG_HI: begin
                hi_d    = add_s;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            signed_q <= 1'b0;
            lz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            signed_q <= signed_d;
            lz_q     <= lz_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request a multiply; sampled only in IDLE.
REQ-004 SHALL have port is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-005 SHALL have ports A and B, input, 32 each, multiplicand and multiplier; sampled with start.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port done, output, 1, one-cycle pulse marking HI/LO valid.
REQ-008 SHALL have ports HI and LO, output, 32 each, upper and lower words of the 64-bit product.

Function
REQ-009 SHALL perform every addition through exactly one instance of the team's 32-bit carry-lookahead adder (A, B, cin, S, overflow), with its operands muxed by state; no other adders or "+" operators.
REQ-010 SHALL derive the adder's carry-out as (a31&b31)|((a31|b31)&~s31), because the adder exposes only overflow.
REQ-011 SHALL implement the states IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI and DONE, encoded in a 3-bit register.
REQ-012 IDLE with start=1 SHALL latch A, B, is_signed and sign = is_signed&(A[31]^B[31]), clear HI and LO, then go to ABS_A if is_signed, else to MUL with count=0.
REQ-013 ABS_A SHALL replace mcand with ~mcand+1 (adder inputs ~mcand, 0, cin=1) if mcand[31]=1, else hold it, then go to ABS_B.
REQ-014 ABS_B SHALL apply the same rule to mplier, then go to MUL with count=0.
REQ-015 Each MUL cycle SHALL form sum = HI+(LO[0] ? mcand : 0) with cin=0, then {HI,LO} <= {carry,sum,LO[31:1]}; mplier is loaded into LO at entry and is shifted out of it.
REQ-016 MUL SHALL run exactly 32 cycles using a 5-bit count, leaving count=31 to NEG_LO if sign=1, else to DONE.
REQ-017 NEG_LO SHALL set LO <= ~LO+1 and store the flag lz = carry-out (1 iff LO was 0).
REQ-018 NEG_HI SHALL set HI <= ~HI+lz (cin=lz), then go to DONE.
REQ-019 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-020 Latency from the edge sampling start to the done cycle SHALL be 33 cycles for unsigned, 35 cycles for signed with sign=0, and 37 cycles for signed with sign=1.
REQ-021 start SHALL be ignored in every state except IDLE; operands and the operation in flight are unaffected.
REQ-022 HI and LO SHALL hold the last product after DONE until the next accepted start.
REQ-023 -2^31 operands SHALL be handled as unsigned magnitude 0x80000000 (ABS leaves the bit pattern unchanged); the product is exact over the full 64 bits and never saturates.
REQ-024 start in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL be accepted (back-to-back throughput of one operation per latency+1 cycles).

Reset
REQ-025 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, HI=0, LO=0, count=0, sign=0, lz=0 and clear the mcand and mplier registers.
REQ-026 reset asserted mid-operation SHALL abandon the operation with no done pulse; the first start after reset deasserts SHALL behave as a fresh operation.

Verification
REQ-027 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done 33 cycles after start.
REQ-028 Signed 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000, done at 35 cycles.
REQ-029 Signed 7 x 0xFFFFFFFD -> HI=0xFFFFFFFF, LO=0xFFFFFFEB at 37 cycles; signed 0 x 0xFFFFFFFB -> HI=LO=0 at 37 cycles (lz=1 path).
REQ-030 Unsigned 5 x 6 started, then start pulsed with 9 x 9 at cycle 10 -> HI=0, LO=30, done at 33, and exactly one done pulse.
REQ-031 reset asserted at MUL cycle 12 -> busy, done, HI and LO are 0 before the next edge; a following unsigned 3 x 4 -> LO=12 at 33 cycles.
REQ-032 Back-to-back: start held high continuously -> the second operation is accepted in the IDLE cycle after DONE, and its done follows that acceptance by the REQ-020 latency.
